// File: rtl/fullconnect_core_read_master_if.sv
// fullconnect_core_read_master_if
// Bundles the FullConnect read master's control, ReadBuffer stream and
// Avalon-MM read port. The master modport is the read master's view; the
// slave modport is the view of whatever sits on the far side (TOP FSM,
// ReadBuffer and Avalon slave together).

interface fullconnect_core_read_master_if #(
    parameter int AvalonByteEnable_WIDTH = 64,
    parameter int AvalonData_WIDTH       = 512
);
    logic                              Start_i;
    logic [63:0]                       InitialAddr;
    logic [AvalonData_WIDTH-1:0]       ReadData_o;
    logic                              ReadValid_o;
    logic                              ReadReady_i;
    logic [63:0]                       AvalonAddr_o;
    logic                              AvalonRead_o;
    logic                              AvalonWrite_o;
    logic [AvalonByteEnable_WIDTH-1:0] AvalonByteEnable_o;
    logic [AvalonData_WIDTH-1:0]       AvalonWriteData_o;
    logic [AvalonData_WIDTH-1:0]       AvalonReadData_i;
    logic                              AvalonReadDataValid_i;
    logic                              AvalonLock_o;
    logic                              AvalonWaitReq_i;
    logic                              Done_o;

    modport master (
        input  Start_i, InitialAddr, ReadReady_i,
        input  AvalonReadData_i, AvalonReadDataValid_i, AvalonWaitReq_i,
        output ReadData_o, ReadValid_o,
        output AvalonAddr_o, AvalonRead_o, AvalonWrite_o, AvalonByteEnable_o,
        output AvalonWriteData_o, AvalonLock_o, Done_o
    );

    modport slave (
        output Start_i, InitialAddr, ReadReady_i,
        output AvalonReadData_i, AvalonReadDataValid_i, AvalonWaitReq_i,
        input  ReadData_o, ReadValid_o,
        input  AvalonAddr_o, AvalonRead_o, AvalonWrite_o, AvalonByteEnable_o,
        input  AvalonWriteData_o, AvalonLock_o, Done_o
    );
endinterface

// File: rtl/fullconnect_core_read_master.sv
// fullconnect_core_read_master
// Avalon-MM read-only master for the FullConnect core. On Start_i it issues
// READ_NUM single-beat pipelined reads, buffers the returned words in a
// credit-limited response FIFO, streams them to the ReadBuffer over
// valid/ready and raises Done_o once every word has been delivered.
// Optional feature macro: FULLCONNECT_READ_ADDR_INC_EN -- when defined the
// read address advances by one beat (AvalonByteEnable_WIDTH bytes) after each
// accepted command; when undefined every command reuses InitialAddr.

module fullconnect_core_read_master #(
    parameter logic [8:0] READ_NUM               = 9'h1,
    parameter int         AvalonByteEnable_WIDTH = 64,
    parameter int         AvalonData_WIDTH       = 512,
    parameter int         MAX_PENDING            = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    fullconnect_core_read_master_if.master bus
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1'b1);
    localparam logic [OCC_W-1:0] OCC_ONE    = OCC_W'(1'b1);
    localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(MAX_PENDING);
    localparam logic [9:0]       PEND_LIMIT = 10'(MAX_PENDING);
`ifdef FULLCONNECT_READ_ADDR_INC_EN
    localparam logic [63:0]      ADDR_STEP  = 64'(AvalonByteEnable_WIDTH);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                      state_q, state_d;
    logic                        rd_q, rd_d;
    logic [63:0]                 addr_q, addr_d;
    logic [8:0]                  issue_cnt_q, issue_cnt_d;
    logic [8:0]                  recv_cnt_q, recv_cnt_d;
    logic [8:0]                  send_cnt_q, send_cnt_d;
    logic [AvalonData_WIDTH-1:0] mem_q [MAX_PENDING];
    logic [AvalonData_WIDTH-1:0] mem_d [MAX_PENDING];
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]            occ_q, occ_d;
    logic                        valid_q, valid_d;
    logic                        done_q, done_d;

    logic                        active_s;
    logic                        start_s;
    logic                        accept_s;
    logic                        push_s;
    logic                        pop_s;
    logic [8:0]                  send_next_s;
    logic [9:0]                  pending_s;

    // Handshake qualifiers shared by the FSM and the datapath.
    assign active_s    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign start_s     = (state_q == ST_IDLE) && bus.Start_i;
    assign accept_s    = rd_q && !bus.AvalonWaitReq_i;
    assign pop_s       = valid_q && bus.ReadReady_i;
    // Responses outside an active transfer are dropped; the full/recv guards
    // only matter for a misbehaving slave since credits already bound them.
    assign push_s      = bus.AvalonReadDataValid_i && active_s &&
                         (recv_cnt_q != READ_NUM) &&
                         ((occ_q != OCC_FULL) || pop_s);
    assign send_next_s = pop_s ? (send_cnt_q + 9'd1) : send_cnt_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; DRAIN looks at the post-pop count so Done_o
    // rises in the cycle right after the final pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start_i) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (accept_s && (issue_cnt_q == (READ_NUM - 9'd1))) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (send_next_s == READ_NUM) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (!bus.Start_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values: counters, response FIFO, credit-gated
    // command generation and the registered status outputs.
    always_comb begin
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        send_cnt_d  = send_cnt_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        rd_d        = 1'b0;
        pending_s   = 10'd0;
        valid_d     = 1'b0;
        done_d      = 1'b0;

        if (start_s) begin
            addr_d      = bus.InitialAddr;
            issue_cnt_d = 9'd0;
            recv_cnt_d  = 9'd0;
            send_cnt_d  = 9'd0;
        end else begin
            if (accept_s) begin
                issue_cnt_d = issue_cnt_q + 9'd1;
`ifdef FULLCONNECT_READ_ADDR_INC_EN
                addr_d      = addr_q + ADDR_STEP;
`else
                addr_d      = addr_q;
`endif
            end else begin
                issue_cnt_d = issue_cnt_q;
                addr_d      = addr_q;
            end
            if (push_s) begin
                recv_cnt_d = recv_cnt_q + 9'd1;
            end else begin
                recv_cnt_d = recv_cnt_q;
            end
            send_cnt_d = send_next_s;
        end

        if (push_s) begin
            mem_d[wr_ptr_q] = bus.AvalonReadData_i;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase

        // Credits in flight next cycle: issued-but-unanswered plus buffered.
        pending_s = {1'b0, issue_cnt_d - recv_cnt_d} + 10'(occ_d);

        if (rd_q && bus.AvalonWaitReq_i) begin
            rd_d = 1'b1;
        end else if ((state_d == ST_ISSUE) && (issue_cnt_d < READ_NUM) &&
                     (pending_s < PEND_LIMIT)) begin
            rd_d = 1'b1;
        end else begin
            rd_d = 1'b0;
        end

        valid_d = (occ_d != {OCC_W{1'b0}});
        done_d  = (state_d == ST_DONE);
    end

    // Datapath registers; reset clears the FIFO contents too.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_q        <= 1'b0;
            addr_q      <= 64'd0;
            issue_cnt_q <= 9'd0;
            recv_cnt_q  <= 9'd0;
            send_cnt_q  <= 9'd0;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            occ_q       <= {OCC_W{1'b0}};
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < MAX_PENDING; i++) begin
                mem_q[i] <= {AvalonData_WIDTH{1'b0}};
            end
        end else begin
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            send_cnt_q  <= send_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            mem_q       <= mem_d;
        end
    end

    assign bus.ReadData_o         = mem_q[rd_ptr_q];
    assign bus.ReadValid_o        = valid_q;
    assign bus.AvalonAddr_o       = addr_q;
    assign bus.AvalonRead_o       = rd_q;
    assign bus.AvalonLock_o       = rd_q;
    assign bus.AvalonWrite_o      = 1'b0;
    assign bus.AvalonByteEnable_o = {AvalonByteEnable_WIDTH{1'b1}};
    assign bus.AvalonWriteData_o  = {AvalonData_WIDTH{1'b0}};
    assign bus.Done_o             = done_q;

endmodule

// File: tb/tb_fullconnect_core_read_master.sv
// tb_fullconnect_core_read_master
// Self-checking bench: a table of transfer configurations plus randomized
// transfers run against a queue-based model of the read master (commands in
// order, responses buffered, words delivered in order, credit limit), and
// hand-written sequences for back-pressure, wait request, reset abort, the
// Done handshake and a single-beat instance.

module tb_fullconnect_core_read_master;

    localparam int N    = 5;
    localparam int MAXP = 4;
`ifdef FULLCONNECT_READ_ADDR_INC_EN
    localparam logic [63:0] ADDR_INC = 64'd64;
`else
    localparam logic [63:0] ADDR_INC = 64'd0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fullconnect_core_read_master_if #(.AvalonByteEnable_WIDTH(64), .AvalonData_WIDTH(512)) bus ();
    fullconnect_core_read_master_if #(.AvalonByteEnable_WIDTH(64), .AvalonData_WIDTH(512)) bus1 ();

    fullconnect_core_read_master #(
        .READ_NUM(9'd5), .AvalonByteEnable_WIDTH(64), .AvalonData_WIDTH(512), .MAX_PENDING(4)
    ) dut (.clk(clk), .rstn(rstn), .bus(bus));

    fullconnect_core_read_master #(
        .READ_NUM(9'd1), .AvalonByteEnable_WIDTH(64), .AvalonData_WIDTH(512), .MAX_PENDING(4)
    ) dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

    typedef struct {
        logic [63:0] addr;
        int          lat_lo;
        int          lat_hi;
        int          wait_pct;
        int          ready_pct;
        int          exp_beats;
        logic [63:0] exp_last_addr;
    } vec_t;

    vec_t vecs[4];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // model state for the main instance
    logic [63:0]  base_addr, last_addr;
    int           nacc, nrcv, nbuf, nsent, last_due, held;
    logic [511:0] exp_q[$];
    logic [511:0] rdata_q[$];
    int           due_q[$];
    int           lat_lo, lat_hi, wait_pct, ready_pct, wait_cmd, wait_left;

    logic         s_rd, s_valid, s_done;
    logic [63:0]  s_addr;
    logic [511:0] s_data;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [511:0] rand_word();
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [63:0] exp_addr(input int k);
        return base_addr + 64'(k) * ADDR_INC;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic sample();
        s_rd    = bus.AvalonRead_o;
        s_valid = bus.ReadValid_o;
        s_done  = bus.Done_o;
        s_addr  = bus.AvalonAddr_o;
        s_data  = bus.ReadData_o;
    endtask

    task automatic begin_transfer(input logic [63:0] addr);
        nacc = 0; nrcv = 0; nbuf = 0; nsent = 0; held = 0;
        last_due = cyc;
        exp_q.delete(); rdata_q.delete(); due_q.delete();
        base_addr = addr;
        last_addr = 64'd0;
        bus.InitialAddr           = addr;
        bus.Start_i               = 1'b1;
        bus.AvalonWaitReq_i       = 1'b0;
        bus.AvalonReadDataValid_i = 1'b0;
        bus.ReadReady_i           = (int'($urandom_range(99)) < ready_pct);
    endtask

    // One clock of the main instance: account for what happened at the edge,
    // check the new outputs, then drive the next cycle's slave/sink inputs.
    task automatic step();
        logic         acc, pushed, popped, held_now;
        logic [63:0]  pre_addr;
        logic [511:0] pre_data, w;
        int           d;
        acc      = s_rd && !bus.AvalonWaitReq_i;
        held_now = s_rd && bus.AvalonWaitReq_i;
        pushed   = bus.AvalonReadDataValid_i;
        popped   = s_valid && bus.ReadReady_i;
        pre_addr = s_addr;
        pre_data = s_data;
        tick();
        sample();
        if (acc) begin
            check("cmd_addr", pre_addr, exp_addr(nacc));
            check("cmd_within_count", nacc < N, 1'b1);
            last_addr = pre_addr;
            w = rand_word();
            d = cyc - 1 + int'($urandom_range(lat_hi, lat_lo));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            exp_q.push_back(w);
            rdata_q.push_back(w);
            due_q.push_back(d);
            nacc++;
        end
        if (pushed) begin
            nrcv++;
            nbuf++;
        end
        if (popped) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 1'b1, 1'b0);
            end else begin
                check("read_data", pre_data, exp_q.pop_front());
            end
            nbuf--;
            nsent++;
        end
        check("read_valid", s_valid, nbuf > 0);
        check("done", s_done, nsent == N);
        check("lock_eq_read", bus.AvalonLock_o, s_rd);
        if (held_now) begin
            check("hold_read", s_rd, 1'b1);
            check("hold_addr", s_addr, pre_addr);
            held++;
        end
        if (s_rd) check("credit", (nacc - nrcv + nbuf + 1) <= MAXP, 1'b1);

        if (s_rd && nacc == wait_cmd && wait_left > 0) begin
            bus.AvalonWaitReq_i = 1'b1;
            wait_left--;
        end else begin
            bus.AvalonWaitReq_i = (int'($urandom_range(99)) < wait_pct);
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            bus.AvalonReadDataValid_i = 1'b1;
            bus.AvalonReadData_i      = rdata_q.pop_front();
            due_q.delete(0);
        end else begin
            bus.AvalonReadDataValid_i = 1'b0;
            bus.AvalonReadData_i      = rand_word();
        end
        bus.ReadReady_i = (int'($urandom_range(99)) < ready_pct);
    endtask

    task automatic run_to_done(input int budget, input int exp_beats);
        int n = 0;
        while (!s_done && n < budget) begin
            step();
            n++;
        end
        check("done_reached", s_done, 1'b1);
        check("beats_issued", nacc, exp_beats);
        check("beats_delivered", nsent, exp_beats);
    endtask

    task automatic finish_transfer();
        bus.Start_i               = 1'b0;
        bus.AvalonReadDataValid_i = 1'b0;
        bus.AvalonWaitReq_i       = 1'b0;
        tick();
        sample();
        check("done_drop", s_done, 1'b0);
        check("idle_no_read", s_rd, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [511:0] w1;

        vecs[0] = '{64'h1000,      1, 1,  0, 100, N, 64'h1000 + 64'd4 * ADDR_INC};
        vecs[1] = '{64'h2000,      2, 5, 30,  60, N, 64'h2000 + 64'd4 * ADDR_INC};
        vecs[2] = '{64'hDEAD_0000, 1, 3, 50,  20, N, 64'hDEAD_0000 + 64'd4 * ADDR_INC};
        vecs[3] = '{64'h40,        3, 3,  0, 100, N, 64'h40 + 64'd4 * ADDR_INC};

        bus.Start_i = 1'b0; bus.InitialAddr = 64'd0; bus.ReadReady_i = 1'b0;
        bus.AvalonReadData_i = 512'd0; bus.AvalonReadDataValid_i = 1'b0; bus.AvalonWaitReq_i = 1'b0;
        bus1.Start_i = 1'b0; bus1.InitialAddr = 64'h80; bus1.ReadReady_i = 1'b1;
        bus1.AvalonReadData_i = 512'd0; bus1.AvalonReadDataValid_i = 1'b0; bus1.AvalonWaitReq_i = 1'b0;
        wait_cmd = -1; wait_left = 0;

        // reset values
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        sample();
        check("rst_read", s_rd, 1'b0);
        check("rst_lock", bus.AvalonLock_o, 1'b0);
        check("rst_addr", s_addr, 64'd0);
        check("rst_valid", s_valid, 1'b0);
        check("rst_done", s_done, 1'b0);
        check("write_tied", bus.AvalonWrite_o, 1'b0);
        check("byteenable_ones", bus.AvalonByteEnable_o, {64{1'b1}});
        check("rst1_valid", bus1.ReadValid_o, 1'b0);

        // table-driven transfers
        for (int v = 0; v < 4; v++) begin
            lat_lo = vecs[v].lat_lo; lat_hi = vecs[v].lat_hi;
            wait_pct = vecs[v].wait_pct; ready_pct = vecs[v].ready_pct;
            begin_transfer(vecs[v].addr);
            run_to_done(400, vecs[v].exp_beats);
            check("vec_last_addr", last_addr, vecs[v].exp_last_addr);
            finish_transfer();
        end

        // randomized transfers
        for (int r = 0; r < 8; r++) begin
            lat_lo = 1; lat_hi = int'($urandom_range(5, 1));
            wait_pct = int'($urandom_range(40)); ready_pct = int'($urandom_range(100, 10));
            begin_transfer({$urandom, $urandom_range(1023), 6'd0});
            run_to_done(600, N);
            finish_transfer();
        end

        // back-pressure: sink stalled, exactly MAXP commands then FIFO full
        lat_lo = 1; lat_hi = 2; wait_pct = 0; ready_pct = 0;
        begin_transfer(64'h3000);
        repeat (20) step();
        check("bp_cmds", nacc, MAXP);
        check("bp_read_low", s_rd, 1'b0);
        check("bp_valid", s_valid, 1'b1);
        ready_pct = 100;
        run_to_done(200, N);
        finish_transfer();

        // wait request on command 2 for 3 cycles
        lat_lo = 1; lat_hi = 1; wait_pct = 0; ready_pct = 100;
        wait_cmd = 1; wait_left = 3;
        begin_transfer(64'h5000);
        run_to_done(200, N);
        check("wait_held_cycles", held, 3);
        wait_cmd = -1;
        finish_transfer();

        // reset after 2 of 5 commands, then late responses must be dropped
        lat_lo = 6; lat_hi = 6; wait_pct = 0; ready_pct = 100;
        begin_transfer(64'h6000);
        n = 0;
        while (nacc < 2 && n < 40) begin
            step();
            n++;
        end
        check("abort_two_cmds", nacc, 2);
        bus.Start_i = 1'b0;
        bus.AvalonReadDataValid_i = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        sample();
        check("abort_read", s_rd, 1'b0);
        check("abort_addr", s_addr, 64'd0);
        for (int k = 0; k < 6; k++) begin
            bus.AvalonReadDataValid_i = 1'b1;
            bus.AvalonReadData_i      = rand_word();
            tick();
            sample();
            check("late_resp_valid", s_valid, 1'b0);
            check("late_resp_done", s_done, 1'b0);
        end
        bus.AvalonReadDataValid_i = 1'b0;
        tick();
        sample();
        check("late_resp_valid_end", s_valid, 1'b0);
        lat_lo = 1; lat_hi = 3;
        begin_transfer(64'h7000);
        run_to_done(300, N);

        // Done handshake: Start_i held high keeps Done_o and starts nothing
        for (int k = 0; k < 4; k++) begin
            tick();
            sample();
            check("done_hold", s_done, 1'b1);
            check("done_no_restart", s_rd, 1'b0);
        end
        finish_transfer();
        begin_transfer(64'h8000);
        run_to_done(300, N);
        finish_transfer();

        // single-beat instance, read latency 2, sink always ready
        w1 = rand_word();
        bus1.Start_i = 1'b1;
        tick();
        check("sb_read_pulse", bus1.AvalonRead_o, 1'b1);
        check("sb_addr", bus1.AvalonAddr_o, 64'h80);
        tick();
        check("sb_read_once", bus1.AvalonRead_o, 1'b0);
        tick();
        check("sb_no_bypass", bus1.ReadValid_o, 1'b0);
        bus1.AvalonReadDataValid_i = 1'b1;
        bus1.AvalonReadData_i      = w1;
        tick();
        bus1.AvalonReadDataValid_i = 1'b0;
        check("sb_valid", bus1.ReadValid_o, 1'b1);
        check("sb_data", bus1.ReadData_o, w1);
        check("sb_done_early", bus1.Done_o, 1'b0);
        tick();
        check("sb_done", bus1.Done_o, 1'b1);
        check("sb_valid_clear", bus1.ReadValid_o, 1'b0);
        check("sb_no_more_read", bus1.AvalonRead_o, 1'b0);
        bus1.Start_i = 1'b0;
        tick();
        check("sb_done_drop", bus1.Done_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fullconnect_core_read_master.md
# fullconnect_core_read_master

Avalon-MM read-only master for the FullConnect core. On a start request it issues READ_NUM single-beat pipelined reads beginning at InitialAddr and buffers the returned words in a small response FIFO. It streams them to the core's ReadBuffer over a valid/ready handshake and raises Done_o once every word has been delivered. It is the load-side counterpart of the core's write master and shares the same Avalon port shape.

## Interface
- READ_NUM, 9'h1: number of beats per transfer, 1..511
- AvalonByteEnable_WIDTH, 64: byte-enable width; bytes per beat
- AvalonData_WIDTH, 512: data width
- MAX_PENDING, 4: maximum of reads outstanding plus words buffered; response FIFO depth; power of 2, 2..16

- clk  in  1  clock
- rstn  in  1  reset; one clock, reset is synchronous and active-low
- Start_i  in  1  level start request from TOP FSM
- InitialAddr  in  64  base address, sampled on start
- ReadData_o  out  AvalonData_WIDTH  word to ReadBuffer
- ReadValid_o  out  1  ReadData_o valid
- ReadReady_i  in  1  ReadBuffer accepts the word
- AvalonAddr_o  out  64  read address
- AvalonRead_o  out  1  read command
- AvalonWrite_o  out  1  tied 0
- AvalonByteEnable_o  out  AvalonByteEnable_WIDTH  all ones
- AvalonWriteData_o  out  AvalonData_WIDTH  tied 0
- AvalonReadData_i  in  AvalonData_WIDTH  response data
- AvalonReadDataValid_i  in  1  response valid
- AvalonLock_o  out  1  equals AvalonRead_o
- AvalonWaitReq_i  in  1  slave stall
- Done_o  out  1  transfer complete, to TOP FSM

## Operation
- FSM states are IDLE, ISSUE, DRAIN and DONE.
  - IDLE -> ISSUE when Start_i=1: latch InitialAddr; clear IssueCnt, RecvCnt and SendCnt.
  - ISSUE: a command is accepted when AvalonRead_o=1 and AvalonWaitReq_i=0. Each accepted command increments IssueCnt. After the accept that makes IssueCnt = READ_NUM: -> DRAIN.
  - DRAIN -> DONE when SendCnt = READ_NUM.
  - DONE: Done_o=1. -> IDLE when Start_i=0.
- Start_i is ignored outside IDLE.
- Credit rule: Pending = (IssueCnt − RecvCnt) + FIFO occupancy. A new command is asserted only while Pending < MAX_PENDING, so the FIFO never overflows.
- Response: each cycle with AvalonReadDataValid_i=1 pushes AvalonReadData_i into the FIFO and increments RecvCnt.
  - Responses arriving in IDLE or DONE are dropped.
- Delivery: ReadValid_o = FIFO not empty, and ReadData_o = FIFO head. A pop occurs when ReadValid_o & ReadReady_i, and each pop increments SendCnt.
- Counters are 9 bits wide and never wrap, because they are bounded by READ_NUM.
- A simultaneous push and pop leaves occupancy unchanged. A push into an empty FIFO is visible as ReadValid_o on the next cycle (no bypass).

## Timing
- AvalonRead_o and AvalonAddr_o are registered.
  - While AvalonWaitReq_i=1 they hold their values.
  - After an accept, the next command may be asserted in the following cycle, giving 1 command per cycle at full credit.
- The first ReadValid_o comes 1 cycle after the first AvalonReadDataValid_i.
- Done_o rises 1 cycle after the pop that makes SendCnt = READ_NUM.
- Reset values:
  - FSM is IDLE.
  - AvalonRead_o=0, AvalonLock_o=0, AvalonAddr_o=0.
  - ReadValid_o=0, Done_o=0.
  - All counters and the FIFO are cleared.
- Reset mid-transfer aborts the transfer. Late responses are then dropped, per the IDLE rule.

## Configuration
- FULLCONNECT_READ_ADDR_INC_EN defined: AvalonAddr_o advances by AvalonByteEnable_WIDTH after each accepted command, so beat k reads InitialAddr + k·AvalonByteEnable_WIDTH.
- Undefined: every command uses InitialAddr unchanged. This is the streaming-slave mode and mirrors the fixed-address write path.

## Test plan
- Single beat:
  - Stimulus: READ_NUM=1, no wait, read latency 2, ReadReady_i=1.
  - Required: one AvalonRead_o pulse; ReadValid_o one cycle after the valid; Done_o the next cycle.
- Back-pressure:
  - Stimulus: READ_NUM=8, MAX_PENDING=4, ReadReady_i=0 throughout.
  - Required: exactly 4 commands issued, then AvalonRead_o=0 with FIFO full. Raising ReadReady_i delivers all 8 words in order and asserts Done_o.
- Wait request:
  - Stimulus: AvalonWaitReq_i=1 for 3 cycles on command 2.
  - Required: AvalonRead_o and AvalonAddr_o stable for those cycles; IssueCnt advances once.
- Address increment, with the macro defined:
  - Stimulus: InitialAddr=0x1000, READ_NUM=3.
  - Required: addresses 0x1000, 0x1040, 0x1080. Without the macro: 0x1000 three times.
- Reset mid-transfer:
  - Stimulus: rstn=0 after 2 of 5 commands, followed by late readdatavalid.
  - Required: no ReadValid_o and Done_o=0. A new Start_i then completes a clean 5-beat transfer.
- Done handshake:
  - Stimulus: Start_i held high after completion.
  - Required: Done_o stays 1, and no new transfer starts until Start_i goes low and then high again.
